// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, symbol/offset widths and the alignment FSM states.
// Transmit-side encoders use the same token constants.
package tmds_pkg;

    localparam int SYM_W = 10;
    localparam int OFS_W = 4;

    localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_t;

    // Rotation offsets cycle through 0..9.
    function automatic logic [OFS_W-1:0] next_offset(input logic [OFS_W-1:0] cur);
        return (cur == OFS_W'(9)) ? '0 : cur + OFS_W'(1);
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: 10-bit symbol to data byte, control bits and token flag.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] q,
    output logic [7:0]       d,
    output logic             c1,
    output logic             c0,
    output logic             is_token
);

    logic [7:0] m;

    assign m    = q[9] ? ~q[7:0] : q[7:0];
    assign d[0] = m[0];

    // q[8] selects between the XOR and XNOR transition chains used by the encoder.
    for (genvar gi = 1; gi < 8; gi++) begin : g_chain
        assign d[gi] = q[8] ? (m[gi] ^ m[gi-1]) : ~(m[gi] ^ m[gi-1]);
    end

    always_comb begin
        is_token = 1'b1;
        c1       = 1'b0;
        c0       = 1'b0;
        case (q)
            TOK_00: ;
            TOK_01: c0 = 1'b1;
            TOK_10: c1 = 1'b1;
            TOK_11: begin
                c1 = 1'b1;
                c0 = 1'b1;
            end
            default: is_token = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder with barrel-rotator word alignment driven by control-token runs.
// Optional macro TMDS_DECODER_ERR_COUNT_EN adds err_count, a counter of short token runs seen while locked.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int C_depth       = 8,
    parameter int C_lock_tokens = 16,
    parameter int C_min_run     = 12,
    parameter int C_dwell       = 1024
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic [SYM_W-1:0]   raw,
    output logic [C_depth-1:0] data,
    output logic               c0,
    output logic               c1,
    output logic               blank,
    output logic               locked,
    output logic [OFS_W-1:0]   offset
`ifdef TMDS_DECODER_ERR_COUNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam int DW = $clog2(C_dwell + 1);

    logic [SYM_W-1:0]   cur_reg;
    logic [SYM_W-1:0]   prev_reg;
    logic [2*SYM_W-1:0] window;
    logic [SYM_W-1:0]   sym;
    logic [7:0]         dec_d;
    logic               dec_c1;
    logic               dec_c0;
    logic               dec_tok;
    logic [7:0]         run_reg;
    logic [DW-1:0]      dwell_reg;
    logic [1:0]         settle_reg;
    tmds_state_t        state_reg;
    logic               count_tok;
    logic               lock_hit;
    logic               expire;

    assign window = {cur_reg, prev_reg};
    assign sym    = window[offset +: SYM_W];

    tmds_symbol_decode u_decode (
        .q        (sym),
        .d        (dec_d),
        .c1       (dec_c1),
        .c0       (dec_c0),
        .is_token (dec_tok)
    );

    // Tokens arriving right after a rotation change straddle two alignments and are ignored.
    assign count_tok = dec_tok && (settle_reg == 2'd0);
    assign lock_hit  = count_tok && (run_reg == 8'(C_lock_tokens - 1));
    assign expire    = (dwell_reg == DW'(C_dwell));

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cur_reg    <= '0;
            prev_reg   <= '0;
            data       <= '0;
            c0         <= 1'b0;
            c1         <= 1'b0;
            blank      <= 1'b1;
            locked     <= 1'b0;
            offset     <= '0;
            run_reg    <= '0;
            dwell_reg  <= '0;
            settle_reg <= '0;
            state_reg  <= SEARCH;
`ifdef TMDS_DECODER_ERR_COUNT_EN
            err_count  <= '0;
`endif
        end else begin
            cur_reg  <= raw;
            prev_reg <= cur_reg;

            if (dec_tok) begin
                blank <= 1'b1;
                c0    <= dec_c0;
                c1    <= dec_c1;
            end else begin
                blank <= 1'b0;
                data  <= dec_d[7 -: C_depth];
            end

            if (!dec_tok) begin
                run_reg <= '0;
            end else if (count_tok && run_reg != 8'hFF) begin
                run_reg <= run_reg + 8'd1;
            end

            if (settle_reg != 2'd0) begin
                settle_reg <= settle_reg - 2'd1;
            end

            if (!expire) begin
                dwell_reg <= dwell_reg + DW'(1);
            end

`ifdef TMDS_DECODER_ERR_COUNT_EN
            // A run that ends too early while aligned points to a corrupted symbol stream.
            if (!dec_tok && locked && run_reg != 8'd0 && run_reg < 8'(C_min_run)
                && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
`endif

            // Later assignments below take priority over the default counter updates above.
            case (state_reg)
                SEARCH: begin
                    if (lock_hit) begin
                        state_reg <= LOCKED;
                        locked    <= 1'b1;
                        dwell_reg <= '0;
                    end else if (expire) begin
                        offset     <= next_offset(offset);
                        run_reg    <= '0;
                        dwell_reg  <= '0;
                        settle_reg <= 2'd2;
                    end
                end
                LOCKED: begin
                    if (lock_hit) begin
                        dwell_reg <= '0;
                    end else if (expire) begin
                        state_reg  <= SEARCH;
                        locked     <= 1'b0;
                        offset     <= next_offset(offset);
                        run_reg    <= '0;
                        dwell_reg  <= '0;
                        settle_reg <= 2'd2;
`ifdef TMDS_DECODER_ERR_COUNT_EN
                        err_count  <= '0;
`endif
                    end
                end
                default: state_reg <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: vector table, encoder-based random stream and alignment scenarios.
module tb_tmds_decoder;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] raw       = '0;
    logic [7:0] data;
    logic       c0, c1, blank, locked;
    logic [3:0] offset;
`ifdef TMDS_DECODER_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    tmds_decoder dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .raw       (raw),
        .data      (data),
        .c0        (c0),
        .c1        (c1),
        .blank     (blank),
        .locked    (locked),
        .offset    (offset)
`ifdef TMDS_DECODER_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [9:0] sym;
        logic [7:0] data;
        logic       c1;
        logic       c0;
        logic       blank;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       c1;
        logic       c0;
        logic       blank;
        bit         chk;
    } exp_t;

    logic [9:0] toks [4];
    exp_t       expq [$];
    bit         bitq [$];
    int         n_pass = 0;
    int         n_chk  = 0;
    int         cyc    = 0;
    int         line_pos = 0;
    bit         tokens_on = 1'b1;
    logic [9:0] line_tok = 10'h354;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_tok(input logic [9:0] s);
        return (s == toks[0]) || (s == toks[1]) || (s == toks[2]) || (s == toks[3]);
    endfunction

    // Reference TMDS encoder (minimise transitions, optional DC inversion).
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input bit inv);
        int         n1;
        bit         use_xnor;
        logic [8:0] qm;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic [9:0] enc_data(input logic [7:0] d);
        logic [9:0] s;
        s = tmds_enc(d, 1'($urandom_range(0, 1)));
        if (is_tok(s)) s = {~s[9], s[8], ~s[7:0]};
        return s;
    endfunction

    // Aligned word stream: outputs lag raw by two edges.
    task automatic push(input logic [9:0] s, input exp_t e);
        exp_t x;
        raw = s;
        @(posedge clk_pixel);
        #1;
        expq.push_back(e);
        if (expq.size() == 3) begin
            x = expq.pop_front();
            if (x.chk) begin
                check("data", 32'(data), 32'(x.data));
                check("blank", 32'(blank), 32'(x.blank));
                check("c1c0", 32'({c1, c0}), 32'({x.c1, x.c0}));
            end
        end
    endtask

    task automatic push_nc(input logic [9:0] s);
        exp_t e;
        e = '{data: 8'h0, c1: 1'b0, c0: 1'b0, blank: 1'b0, chk: 1'b0};
        push(s, e);
    endtask

    // Serial bit stream of 800-symbol lines (20 tokens + data), cut into 10-bit words.
    task automatic stream_tick();
        logic [9:0] s;
        logic [9:0] w;
        while (bitq.size() < 10) begin
            if (line_pos < 20 && tokens_on) s = line_tok;
            else s = enc_data(8'($urandom_range(1, 255)));
            for (int b = 0; b < 10; b++) bitq.push_back(s[b]);
            line_pos = (line_pos == 799) ? 0 : line_pos + 1;
        end
        for (int b = 0; b < 10; b++) w[b] = bitq.pop_front();
        raw = w;
        @(posedge clk_pixel);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, 32'(data), 32'h0);
        check({tag, "_c1c0"}, 32'({c1, c0}), 32'h0);
        check({tag, "_blank"}, 32'(blank), 32'h1);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_offset"}, 32'(offset), 32'h0);
`ifdef TMDS_DECODER_ERR_COUNT_EN
        check({tag, "_err"}, 32'(err_count), 32'h0);
`endif
    endtask

    task automatic do_reset(input int shift);
        reset = 1'b1;
        raw   = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        cyc = 0;
        line_pos = 0;
        tokens_on = 1'b1;
        bitq.delete();
        expq.delete();
        for (int b = 0; b < shift; b++) bitq.push_back(1'b0);
    endtask

    task automatic wait_lock(input int limit, input string tag);
        while (!locked && cyc < limit) stream_tick();
        check({tag, "_locked"}, 32'(locked), 32'h1);
    endtask

    initial begin
        vec_t       tab [9];
        exp_t       e;
        logic [7:0] mdata;
        logic [1:0] mc;
        int         n;

        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

        tab[0] = '{sym: 10'h100, data: 8'h00, c1: 1'b0, c0: 1'b0, blank: 1'b0};
        tab[1] = '{sym: 10'h200, data: 8'hFF, c1: 1'b0, c0: 1'b0, blank: 1'b0};
        tab[2] = '{sym: 10'h0AB, data: 8'hFF, c1: 1'b0, c0: 1'b1, blank: 1'b1};
        tab[3] = '{sym: 10'h101, data: 8'h03, c1: 1'b0, c0: 1'b1, blank: 1'b0};
        tab[4] = '{sym: 10'h154, data: 8'h03, c1: 1'b1, c0: 1'b0, blank: 1'b1};
        tab[5] = '{sym: 10'h1AA, data: 8'hFE, c1: 1'b1, c0: 1'b0, blank: 1'b0};
        tab[6] = '{sym: 10'h2AB, data: 8'hFE, c1: 1'b1, c0: 1'b1, blank: 1'b1};
        tab[7] = '{sym: 10'h300, data: 8'h01, c1: 1'b1, c0: 1'b1, blank: 1'b0};
        tab[8] = '{sym: 10'h354, data: 8'h01, c1: 1'b0, c0: 1'b0, blank: 1'b1};

        // Aligned lock: 16th token enters on edge 16, locked visible after edge 18.
        do_reset(0);
        for (int j = 1; j <= 20; j++) begin
            raw = toks[0];
            @(posedge clk_pixel);
            #1;
            if (j == 17) check("lock_early", 32'(locked), 32'h0);
            if (j == 18) begin
                check("lock_at18", 32'(locked), 32'h1);
                check("lock_offset", 32'(offset), 32'h0);
                check("lock_blank", 32'(blank), 32'h1);
                check("lock_c1c0", 32'({c1, c0}), 32'h0);
            end
        end

`ifdef TMDS_DECODER_ERR_COUNT_EN
        for (int j = 0; j < 3; j++) push_nc(10'h100);
        check("err_after_long_run", 32'(err_count), 32'h0);
        push_nc(toks[0]);
        for (int j = 0; j < 3; j++) push_nc(10'h100);
        check("err_single_token", 32'(err_count), 32'h1);
        for (int j = 0; j < 12; j++) push_nc(toks[0]);
        for (int j = 0; j < 3; j++) push_nc(10'h100);
        check("err_run12", 32'(err_count), 32'h1);
`endif

        for (int i = 0; i < 9; i++) begin
            e = '{data: tab[i].data, c1: tab[i].c1, c0: tab[i].c0, blank: tab[i].blank, chk: 1'b1};
            push(tab[i].sym, e);
        end

        // Random mix of encoded bytes and tokens against the hold-last-value model.
        mdata = tab[8].data;
        mc    = {tab[8].c1, tab[8].c0};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mc = 2'($urandom_range(0, 3));
                e = '{data: mdata, c1: mc[1], c0: mc[0], blank: 1'b1, chk: 1'b1};
                push(toks[mc], e);
            end else begin
                mdata = 8'($urandom_range(0, 255));
                e = '{data: mdata, c1: mc[1], c0: mc[0], blank: 1'b0, chk: 1'b1};
                push(enc_data(mdata), e);
            end
        end
        push_nc(toks[0]);
        push_nc(toks[0]);
        check("still_locked", 32'(locked), 32'h1);
        check("still_offset0", 32'(offset), 32'h0);
        expq.delete();

        // Stream shifted by 3 bits: offset steps every C_dwell+1 cycles until aligned.
        do_reset(3);
        line_tok = toks[3];
        while (cyc < 3075) begin
            stream_tick();
            if (cyc == 1024) check("step_1024", 32'(offset), 32'h0);
            if (cyc == 1025) check("step_1025", 32'(offset), 32'h1);
            if (cyc == 2050) check("step_2050", 32'(offset), 32'h2);
            if (cyc == 3075) check("step_3075", 32'(offset), 32'h3);
        end
        wait_lock(3075 + 1700, "sh3");
        check("sh3_offset", 32'(offset), 32'h3);
        check("sh3_blank", 32'(blank), 32'h1);
        check("sh3_c1c0", 32'({c1, c0}), 32'h3);
        repeat (1200) stream_tick();
        check("sh3_refresh_locked", 32'(locked), 32'h1);
        check("sh3_refresh_offset", 32'(offset), 32'h3);

        // Asynchronous reset while locked at offset 5.
        do_reset(5);
        line_tok = toks[0];
        wait_lock(5 * 1025 + 1700, "sh5");
        check("sh5_offset", 32'(offset), 32'h5);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        #3;

        // Lock at offset 9, withhold tokens: loss after C_dwell+1 cycles, offset wraps to 0.
        do_reset(9);
        line_tok = toks[2];
        wait_lock(9 * 1025 + 1700, "sh9");
        check("sh9_offset", 32'(offset), 32'h9);
        check("sh9_c1c0", 32'({c1, c0}), 32'h2);
        tokens_on = 1'b0;
        n = 0;
        while (locked && n < 1200) begin
            stream_tick();
            n++;
        end
        check("loss_locked", 32'(locked), 32'h0);
        check("loss_delay", 32'(n), 32'd1025);
        check("loss_offset_wrap", 32'(offset), 32'h0);
`ifdef TMDS_DECODER_ERR_COUNT_EN
        check("loss_err_clear", 32'(err_count), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
